gnt_data_mux: RTL

GNT_DATA_MUX -- requirements
Module: gnt_data_mux

---
 rtl/gnt_pkg.sv | 13 +
 rtl/gnt_fifo2.sv | 75 +++++++
 rtl/gnt_data_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/gnt_pkg.sv
// Shared constants and FIFO occupancy encoding for the grant-steered data mux.
package gnt_pkg;

  localparam int unsigned NPORTS = 4;
  localparam int unsigned SRC_W  = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/gnt_fifo2.sv
// Two-entry FIFO whose head entry is held in the output register, so rdata never
// depends combinationally on wdata.
module gnt_fifo2
  import gnt_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         rd_rdy,
  output logic         full_c,
  output logic [W-1:0] rdata,
  output logic         rvld
);

  occ_e         state, state_nxt;
  logic [W-1:0] tail, tail_nxt, rdata_nxt;
  logic         rvld_nxt;
  logic         pop;

  assign pop    = rvld & rd_rdy;
  assign full_c = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rdata <= '0;
      tail  <= '0;
      rvld  <= 1'b0;
    end else begin
      state <= state_nxt;
      rdata <= rdata_nxt;
      tail  <= tail_nxt;
      rvld  <= rvld_nxt;
    end
  end

  // Head lives in rdata; tail only holds the second entry while FULL.
  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata;
    tail_nxt  = tail;
    rvld_nxt  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          rdata_nxt = wdata;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = FULL;
            tail_nxt  = wdata;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: rdata_nxt = wdata;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          state_nxt = ONE;
          rdata_nxt = tail;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    rvld_nxt = (state_nxt != EMPTY);
  end

endmodule

// File: rtl/gnt_data_mux.sv
// Grant-steered 4:1 data mux feeding a 2-entry output FIFO.
// Define GNT_ONEHOT_CHK_EN to block multi-grant cycles and raise a sticky gnt_err.
module gnt_data_mux
  import gnt_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt3,
  input  logic          gnt2,
  input  logic          gnt1,
  input  logic          gnt0,
  input  logic          vld3,
  input  logic          vld2,
  input  logic          vld1,
  input  logic          vld0,
  input  logic [DW-1:0] din3,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din0,
  output logic          rdy3,
  output logic          rdy2,
  output logic          rdy1,
  output logic          rdy0,
  output logic [DW-1:0] dout,
  output logic [1:0]    dout_src,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          gnt_err
);

  localparam int unsigned W = DW + SRC_W;

  logic [NPORTS-1:0] gnt, vld, sel, rdy;
  logic [DW-1:0]     din [NPORTS];
  logic [SRC_W-1:0]  wsrc;
  logic [DW-1:0]     wdat;
  logic [W-1:0]      rdata;
  logic              full_c, push;

  assign gnt    = {gnt3, gnt2, gnt1, gnt0};
  assign vld    = {vld3, vld2, vld1, vld0};
  assign din[0] = din0;
  assign din[1] = din1;
  assign din[2] = din2;
  assign din[3] = din3;

`ifdef GNT_ONEHOT_CHK_EN
  logic multi;
  logic err_q;

  assign multi = |(gnt & (gnt - NPORTS'(1)));
  assign sel   = multi ? '0 : gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       err_q <= 1'b0;
    else if (multi) err_q <= 1'b1;
  end

  assign gnt_err = err_q;
`else
  // Isolate the lowest set grant bit.
  assign sel     = gnt & (~gnt + NPORTS'(1));
  assign gnt_err = 1'b0;
`endif

  // rdy is gated by rst so requesters see no accept while reset is held.
  assign rdy  = sel & {NPORTS{~full_c & rst}};
  assign push = |(rdy & vld);
  assign {rdy3, rdy2, rdy1, rdy0} = rdy;

  always_comb begin
    wsrc = '0;
    wdat = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel[i]) begin
        wsrc = SRC_W'(i);
        wdat = din[i];
      end
    end
  end

  gnt_fifo2 #(
    .W (W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push   (push),
    .wdata  ({wsrc, wdat}),
    .rd_rdy (dout_rdy),
    .full_c (full_c),
    .rdata  (rdata),
    .rvld   (dout_vld)
  );

  assign dout     = rdata[DW-1:0];
  assign dout_src = rdata[W-1:DW];

endmodule
